// File: rtl/tomasulo_pkg.sv
// Constants and the CDB result record shared by the writeback stage,
// the reservation stations and the register bank.
package tomasulo_pkg;

  localparam int NREGS = 6;
  localparam int DW    = 16;
  localparam int TW    = 3;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [3:0]    regnum;
    logic [DW-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with occupancy count; ready comes from registered
// state only, so there is no combinational path from the producer's valid.
module wb_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clock,
  input  logic resetn,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     head_o,
  output logic ready_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  // NOTE: storage has no reset; an entry is only read after its push, and
  // leaving the array unreset keeps it a plain RAM without reset fan-out.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: always_comb assigns its output before any branch so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign ready_o = (count_q < CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/cdb_writeback.sv
// CDB writeback: two result FIFOs, one grant per cycle, registered broadcast.
// Define CDB_FIXED_PRIO_EN to let source 1 (mul/div) always win contention.
module cdb_writeback
  import tomasulo_pkg::cdb_entry_t;
#(
  parameter int DEPTH = 2,
  parameter int DW    = tomasulo_pkg::DW,
  parameter int TW    = tomasulo_pkg::TW,
  parameter int NREGS = tomasulo_pkg::NREGS
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [TW-1:0] s0_tag,
  input  logic [3:0]    s0_reg,
  input  logic [DW-1:0] s0_data,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [TW-1:0] s1_tag,
  input  logic [3:0]    s1_reg,
  input  logic [DW-1:0] s1_data,
  output logic          cdb_valid,
  output logic [TW-1:0] cdb_tag,
  output logic          write,
  output logic [3:0]    regnumber,
  output logic [DW-1:0] data
);

  cdb_entry_t in0, in1, head0, head1, sel;
  logic       empty0, empty1, gnt0, gnt1;

  assign in0 = '{tag: s0_tag, regnum: s0_reg, data: s0_data};
  assign in1 = '{tag: s1_tag, regnum: s1_reg, data: s1_data};

  wb_fifo #(.DEPTH(DEPTH), .T(cdb_entry_t)) u_fifo0 (
    .clock   (clock),
    .resetn  (resetn),
    .push_i  (s0_valid && s0_ready),
    .din_i   (in0),
    .pop_i   (gnt0),
    .head_o  (head0),
    .ready_o (s0_ready),
    .empty_o (empty0)
  );

  wb_fifo #(.DEPTH(DEPTH), .T(cdb_entry_t)) u_fifo1 (
    .clock   (clock),
    .resetn  (resetn),
    .push_i  (s1_valid && s1_ready),
    .din_i   (in1),
    .pop_i   (gnt1),
    .head_o  (head1),
    .ready_o (s1_ready),
    .empty_o (empty1)
  );

`ifdef CDB_FIXED_PRIO_EN
  assign gnt1 = !empty1;
  assign gnt0 = !empty0 && empty1;
`else
  // last_q records the most recently granted source; reset value 1 lets
  // source 0 win the first contention.
  logic last_q;

  assign gnt0 = !empty0 && (empty1 || last_q);
  assign gnt1 = !empty1 && (empty0 || !last_q);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   last_q <= 1'b1;
    else if (gnt0) last_q <= 1'b0;
    else if (gnt1) last_q <= 1'b1;
  end
`endif

  assign sel = gnt1 ? head1 : head0;

  cdb_entry_t out_q;
  logic       valid_q, write_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      out_q   <= '0;
    end else if (gnt0 || gnt1) begin
      valid_q <= 1'b1;
      // Register 0 and numbers above NREGS mark broadcast-only results.
      write_q <= (sel.regnum != 4'd0) && (sel.regnum <= 4'(NREGS));
      out_q   <= sel;
    end else begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
    end
  end

  assign cdb_valid = valid_q;
  assign write     = write_q;
  assign cdb_tag   = out_q.tag;
  assign regnumber = out_q.regnum;
  assign data      = out_q.data;

endmodule

// File: tb/tb_cdb_writeback.sv
// Randomized and directed bench for cdb_writeback against a queue-based
// reference model; honours CDB_FIXED_PRIO_EN when defined.
module tb_cdb_writeback;
  import tomasulo_pkg::*;

  localparam int DEPTH = 2;

  logic          clock = 1'b0;
  logic          resetn;
  logic          s0_valid, s0_ready, s1_valid, s1_ready;
  logic [TW-1:0] s0_tag, s1_tag, cdb_tag;
  logic [3:0]    s0_reg, s1_reg, regnumber;
  logic [DW-1:0] s0_data, s1_data, data;
  logic          cdb_valid, write;

  int n_checks = 0;
  int n_errors = 0;

  cdb_writeback #(.DEPTH(DEPTH), .DW(DW), .TW(TW), .NREGS(NREGS)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .s0_valid  (s0_valid),
    .s0_ready  (s0_ready),
    .s0_tag    (s0_tag),
    .s0_reg    (s0_reg),
    .s0_data   (s0_data),
    .s1_valid  (s1_valid),
    .s1_ready  (s1_ready),
    .s1_tag    (s1_tag),
    .s1_reg    (s1_reg),
    .s1_data   (s1_data),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .write     (write),
    .regnumber (regnumber),
    .data      (data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per-source queues plus the identity of the last winner.
  cdb_entry_t q0[$], q1[$];
  int         last_src;
  logic       exp_valid, exp_write;
  cdb_entry_t exp_out;

  function automatic cdb_entry_t mk(input int t, input int r, input int d);
    cdb_entry_t e;
    e.tag    = TW'(t);
    e.regnum = 4'(r);
    e.data   = DW'(d);
    return e;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    last_src  = 1;
    exp_valid = 1'b0;
    exp_write = 1'b0;
    exp_out   = '0;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".cdb_valid"}, 32'(cdb_valid), 32'(exp_valid));
    check({ctx, ".write"},     32'(write),     32'(exp_write));
    check({ctx, ".cdb_tag"},   32'(cdb_tag),   32'(exp_out.tag));
    check({ctx, ".regnumber"}, 32'(regnumber), 32'(exp_out.regnum));
    check({ctx, ".data"},      32'(data),      32'(exp_out.data));
  endtask

  task automatic cycle(input string ctx, input logic v0, input cdb_entry_t e0,
                       input logic v1, input cdb_entry_t e1,
                       output logic acc0, output logic acc1);
    logic       r0, r1;
    int         src;
    cdb_entry_t g;
    s0_valid = v0; s0_tag = e0.tag; s0_reg = e0.regnum; s0_data = e0.data;
    s1_valid = v1; s1_tag = e1.tag; s1_reg = e1.regnum; s1_data = e1.data;
    r0 = (q0.size() < DEPTH);
    r1 = (q1.size() < DEPTH);
    #1;
    check({ctx, ".s0_ready"}, 32'(s0_ready), 32'(r0));
    check({ctx, ".s1_ready"}, 32'(s1_ready), 32'(r1));
    acc0 = v0 && r0;
    acc1 = v1 && r1;
    @(posedge clock);
    src = -1;
    if (q0.size() > 0 && q1.size() > 0) begin
`ifdef CDB_FIXED_PRIO_EN
      src = 1;
`else
      src = (last_src == 0) ? 1 : 0;
`endif
    end else if (q0.size() > 0) src = 0;
    else if (q1.size() > 0)     src = 1;
    if (src >= 0) begin
      g = (src == 0) ? q0.pop_front() : q1.pop_front();
      last_src  = src;
      exp_valid = 1'b1;
      exp_write = (g.regnum >= 1) && (g.regnum <= NREGS);
      exp_out   = g;
    end else begin
      exp_valid = 1'b0;
      exp_write = 1'b0;
    end
    if (acc0) q0.push_back(e0);
    if (acc1) q1.push_back(e1);
    #1;
    check_outputs(ctx);
    s0_valid = 1'b0;
    s1_valid = 1'b0;
  endtask

  task automatic idle(input string ctx);
    logic a, b;
    cycle(ctx, 1'b0, '0, 1'b0, '0, a, b);
  endtask

  task automatic apply_reset(input string ctx);
    resetn = 1'b0;
    #1;
    model_reset();
    check_outputs(ctx);
    check({ctx, ".s0_ready"}, 32'(s0_ready), 32'd1);
    check({ctx, ".s1_ready"}, 32'(s1_ready), 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    logic a, b, saw_low;
    int   acc_cnt, budget;
    cdb_entry_t bp[4];
    s0_valid = 1'b0; s0_tag = '0; s0_reg = '0; s0_data = '0;
    s1_valid = 1'b0; s1_tag = '0; s1_reg = '0; s1_data = '0;
    #2;
    apply_reset("reset");

    // Contention straight after reset: s0 first under round-robin.
    cycle("cont.push", 1'b1, mk(1, 1, 'h0011), 1'b1, mk(5, 2, 'h0022), a, b);
    idle("cont.beat1");
`ifdef CDB_FIXED_PRIO_EN
    check("cont.first_tag", 32'(cdb_tag), 32'd5);
`else
    check("cont.first_tag", 32'(cdb_tag), 32'd1);
`endif
    idle("cont.beat2");
`ifdef CDB_FIXED_PRIO_EN
    check("cont.second_tag", 32'(cdb_tag), 32'd1);
`else
    check("cont.second_tag", 32'(cdb_tag), 32'd5);
`endif
    for (int i = 0; i < 4; i++)
      cycle("cont.repeat", 1'b1, mk(i, 1, 'h100 + i), 1'b1, mk(4 + i, 2, 'h200 + i), a, b);
    repeat (5) idle("cont.drain");

    // Single uncontended result: visible one edge after the push.
    cycle("single.push", 1'b1, mk(2, 3, 'h00A5), 1'b0, '0, a, b);
    idle("single.beat");
    check("single.data", 32'(data), 32'h00A5);
    check("single.write", 32'(write), 32'd1);
    idle("single.after");
    check("single.after_valid", 32'(cdb_valid), 32'd0);

    // Broadcast-only beats from source 1.
    cycle("bcast0.push", 1'b0, '0, 1'b1, mk(6, 0, 'hFFFF), a, b);
    idle("bcast0.beat");
    check("bcast0.write", 32'(write), 32'd0);
    cycle("bcast7.push", 1'b0, '0, 1'b1, mk(3, 7, 'hFFFF), a, b);
    idle("bcast7.beat");
    check("bcast7.valid", 32'(cdb_valid), 32'd1);
    check("bcast7.write", 32'(write), 32'd0);

    // Backpressure: four s0 results while s1 is kept busy.
    for (int i = 0; i < 4; i++) bp[i] = mk(i, i + 1, 'hB000 + i);
    acc_cnt = 0; budget = 0; saw_low = 1'b0;
    while (acc_cnt < 4 && budget < 20) begin
      if (!s0_ready) saw_low = 1'b1;
      cycle("bp", 1'b1, bp[acc_cnt], 1'b1, mk(7, 4, 'hC000 + budget), a, b);
      if (a) acc_cnt++;
      budget++;
    end
    check("bp.accepted", 32'(acc_cnt), 32'd4);
    check("bp.ready_dropped", 32'(saw_low), 32'd1);
    repeat (8) idle("bp.drain");

    // Reset while both queues hold entries: nothing stale afterwards.
    for (int i = 0; i < 3; i++)
      cycle("mid.fill", 1'b1, mk(i, 2, 'hD000 + i), 1'b1, mk(i, 5, 'hE000 + i), a, b);
    check("mid.q_nonempty", 32'(q0.size() + q1.size() > 0), 32'd1);
    apply_reset("mid.reset");
    repeat (3) idle("mid.after");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", $urandom_range(0, 3) != 0,
            mk($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 65535)),
            $urandom_range(0, 3) != 0,
            mk($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 65535)),
            a, b);
    end
    repeat (6) idle("rand.drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
